mod_sha256_compress: RTL and testbench

SHA-256 compression engine that sits directly downstream of the `MOD_W_MEM` message-schedule stage. It drives the schedule index, consumes one expanded word W[t] per cycle, runs the 64 compression rounds over working registers a..h, and folds the result into the running hash state H0..H7. H persists across blocks, so multi-block messages are hashed by issuing START once per 512-bit block.

---
 rtl/mod_sha256_compress.sv | 102 ++++++++++
 tb/tb_mod_sha256_compress.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_sha256_compress.sv
// SHA-256 compression engine: 64 rounds over a..h fed by an external W[t] schedule, folded into a persistent H0..H7.
// Latency: START at E0 -> rounds at E1..E64 -> FINAL at E65 (DONE pulse, new H_OUT) -> next START accepted at E66.
// Backpressure: none; START/INIT are ignored while busy, and W_IN must be valid combinationally for W_IDX.
// Ports: CLK/RST (sync, active-high), START/INIT (IDLE-only commands), W_IDX/W_IN (schedule index and word),
//        BUSY/DONE (status), H_OUT = {H0..H7} with H0 in [255:224].
module mod_sha256_compress (
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic         INIT,
  output logic [5:0]   W_IDX,
  input  logic [31:0]  W_IN,
  output logic         BUSY,
  output logic         DONE,
  output logic [255:0] H_OUT
);

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL} state_t;

  localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  state_t               state_q;
  logic [5:0]           t_q;
  logic [0:7][31:0]     v_q;   // working registers a..h, index 0 = a
  logic [0:7][31:0]     h_q;   // hash state H0..H7, index 0 = H0 (MSB of H_OUT)
  logic                 busy_q;
  logic                 done_q;

  logic [31:0] s0_d, s1_d, ch_d, maj_d, t1_d, t2_d;

  always_comb begin
    s1_d  = rotr(v_q[4], 6) ^ rotr(v_q[4], 11) ^ rotr(v_q[4], 25);
    ch_d  = (v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6]);
    s0_d  = rotr(v_q[0], 2) ^ rotr(v_q[0], 13) ^ rotr(v_q[0], 22);
    maj_d = (v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]);
    t1_d  = v_q[7] + s1_d + ch_d + K[t_q] + W_IN;
    t2_d  = s0_d + maj_d;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      t_q     <= '0;
      v_q     <= '0;
      h_q     <= IV;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (INIT) begin
            h_q    <= IV;
            busy_q <= 1'b0;
          end else if (START) begin
            v_q     <= h_q;
            t_q     <= '0;
            state_q <= S_ROUND;
            busy_q  <= 1'b1;
          end else begin
            // BUSY is held through the DONE cycle and drops on the first idle edge after it.
            busy_q <= 1'b0;
          end
        end
        S_ROUND: begin
          v_q <= {t1_d + t2_d, v_q[0], v_q[1], v_q[2], v_q[3] + t1_d, v_q[4], v_q[5], v_q[6]};
          // t wraps 63 -> 0, so W_IDX is back at 0 by the time FINAL runs.
          t_q <= t_q + 6'd1;
          if (t_q == 6'd63) state_q <= S_FINAL;
        end
        S_FINAL: begin
          for (int i = 0; i < 8; i++) h_q[i] <= h_q[i] + v_q[i];
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign W_IDX = t_q;
  assign BUSY  = busy_q;
  assign DONE  = done_q;
  assign H_OUT = h_q;

endmodule

// File: tb/tb_mod_sha256_compress.sv
module tb_mod_sha256_compress;

  localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [255:0] DG_HELLO = 256'hc0535e4be2b79ffd93291305436bf889314e4a3faec05ecffcbb7df31ad9e51a;
  localparam logic [255:0] DG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DG_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [255:0] DG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

  localparam logic [511:0] BLK_HELLO = {32'h48656c6c, 32'h6f20776f, 32'h726c6421, 32'h80000000, 352'd0, 32'h60};
  localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'd0, 32'h18};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'd0};
  localparam logic [511:0] BLK_TWO1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK_TWO2  = {480'd0, 32'h1c0};

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         init = 1'b0;
  logic [5:0]   w_idx;
  logic [31:0]  w_in;
  logic         busy;
  logic         done;
  logic [255:0] h_out;

  logic [511:0]  blk_cur = '0;
  logic [2047:0] sched = '0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  mod_sha256_compress dut (
    .CLK(clk), .RST(rst), .START(start), .INIT(init),
    .W_IDX(w_idx), .W_IN(w_in), .BUSY(busy), .DONE(done), .H_OUT(h_out)
  );

  // Stand-in for the upstream schedule stage: W[W_IDX] presented combinationally.
  assign w_in = sched[2047 - 32*w_idx -: 32];

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [2047:0] expand(input logic [511:0] b);
    logic [31:0] w [64];
    logic [2047:0] r;
    for (int t = 0; t < 64; t++) begin
      if (t < 16) w[t] = b[511 - 32*t -: 32];
      else w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
      r[2047 - 32*t -: 32] = w[t];
    end
    return r;
  endfunction

  // Textbook SHA-256 block compression.
  function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] b);
    logic [2047:0] ws;
    logic [31:0] hv [8];
    logic [31:0] a, bb, c, d, e, f, g, h, t1, t2;
    logic [255:0] r;
    ws = expand(b);
    for (int i = 0; i < 8; i++) hv[i] = hin[255 - 32*i -: 32];
    a = hv[0]; bb = hv[1]; c = hv[2]; d = hv[3]; e = hv[4]; f = hv[5]; g = hv[6]; h = hv[7];
    for (int t = 0; t < 64; t++) begin
      t1 = h + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + KT[t] + ws[2047 - 32*t -: 32];
      t2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & bb) ^ (a & c) ^ (bb & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = bb; bb = a; a = t1 + t2;
    end
    r = {hv[0] + a, hv[1] + bb, hv[2] + c, hv[3] + d, hv[4] + e, hv[5] + f, hv[6] + g, hv[7] + h};
    return r;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Transaction-level model: phase counts edges since the accepted START (-1 = ready).
  logic [255:0] m_h = IV;
  logic [511:0] m_blk = '0;
  int           m_phase = -1;
  bit           m_done = 0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_h = IV; m_phase = -1; m_done = 0;
    end else begin
      m_done = 0;
      if (m_phase >= 0) begin
        m_phase++;
        if (m_phase == 65) begin
          m_h = sha_compress(m_h, m_blk);
          m_done = 1;
        end else if (m_phase == 66) begin
          m_phase = -1;
        end
      end
      if (m_phase < 0) begin
        if (init) m_h = IV;
        else if (start) begin m_phase = 0; m_blk = blk_cur; end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", {255'd0, busy}, {255'd0, m_phase >= 0});
      check("done", {255'd0, done}, {255'd0, m_done});
      check("w_idx", {250'd0, w_idx}, (m_phase >= 0 && m_phase <= 63) ? 256'(m_phase) : 256'd0);
      check("h_out", h_out, m_h);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_block(input logic [511:0] b);
    blk_cur = b;
    sched = expand(b);
  endtask

  task automatic do_init();
    init = 1'b1; tick(); init = 1'b0;
  endtask

  task automatic start_block(input logic [511:0] b);
    load_block(b);
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic wait_done(input string name, output int n);
    bit found;
    found = 0; n = 0;
    for (int i = 1; i <= 200 && !found; i++) begin
      tick();
      if (done === 1'b1) begin found = 1; n = i; end
    end
    if (!found) check({name, "_timeout"}, 256'd0, 256'd1);
  endtask

  initial begin
    int n, c1, c2, bcnt, ndone, at;

    // Pin the model against known digests.
    check("model_hello", sha_compress(IV, BLK_HELLO), DG_HELLO);
    check("model_abc", sha_compress(IV, BLK_ABC), DG_ABC);
    check("model_empty", sha_compress(IV, BLK_EMPTY), DG_EMPTY);
    check("model_two", sha_compress(sha_compress(IV, BLK_TWO1), BLK_TWO2), DG_TWO);

    rst = 1'b1; tick(); tick(); rst = 1'b0;
    chk_en = 1;
    check("rst_busy", {255'd0, busy}, 256'd0);
    check("rst_done", {255'd0, done}, 256'd0);
    check("rst_widx", {250'd0, w_idx}, 256'd0);
    check("rst_h", h_out, IV);

    // Hello world from the reset IV.
    start_block(BLK_HELLO);
    wait_done("hello", n);
    check("hello_lat", 256'(n), 256'd65);
    check("hello_h", h_out, DG_HELLO);
    tick(); tick();

    // abc after INIT; BUSY must cover exactly 66 cycles.
    do_init();
    load_block(BLK_ABC);
    bcnt = 0;
    start = 1'b1;
    for (int i = 0; i < 80; i++) begin
      tick();
      start = 1'b0;
      if (busy === 1'b1) bcnt++;
    end
    check("abc_busy_cycles", 256'(bcnt), 256'd66);
    check("abc_h", h_out, DG_ABC);

    // Two-block message, second START sampled at the earliest edge.
    do_init();
    start_block(BLK_TWO1);
    wait_done("two1", n);
    c1 = cyc;
    start_block(BLK_TWO2);
    wait_done("two2", n);
    c2 = cyc;
    check("two_done_gap", 256'(c2 - c1), 256'd66);
    check("two_h", h_out, DG_TWO);
    tick();

    // Empty message.
    do_init();
    start_block(BLK_EMPTY);
    wait_done("empty", n);
    check("empty_h", h_out, DG_EMPTY);
    tick();

    // Reset in the middle of the rounds.
    do_init();
    start_block(BLK_ABC);
    for (int i = 0; i < 100 && w_idx != 6'd30; i++) tick();
    check("mid_widx_reached", {250'd0, w_idx}, 256'd30);
    rst = 1'b1; tick(); rst = 1'b0;
    check("mid_rst_busy", {255'd0, busy}, 256'd0);
    check("mid_rst_done", {255'd0, done}, 256'd0);
    check("mid_rst_widx", {250'd0, w_idx}, 256'd0);
    check("mid_rst_h", h_out, IV);
    start_block(BLK_ABC);
    wait_done("after_rst", n);
    check("after_rst_h", h_out, DG_ABC);
    tick();

    // START/INIT noise during the rounds must not disturb the block.
    do_init();
    start_block(BLK_ABC);
    ndone = 0; at = 0;
    for (int i = 1; i <= 70; i++) begin
      if (i <= 60) begin
        start = 1'($urandom_range(0, 1));
        init  = 1'($urandom_range(0, 1));
      end else begin
        start = 1'b0; init = 1'b0;
      end
      tick();
      if (done === 1'b1) begin ndone++; at = i; end
    end
    start = 1'b0; init = 1'b0;
    check("noise_done_count", 256'(ndone), 256'd1);
    check("noise_done_edge", 256'(at), 256'd65);
    check("noise_h", h_out, DG_ABC);

    // INIT wins over START in IDLE.
    init = 1'b1; start = 1'b1; tick(); init = 1'b0; start = 1'b0;
    check("both_h", h_out, IV);
    check("both_busy", {255'd0, busy}, 256'd0);
    tick(); tick();
    check("both_busy_later", {255'd0, busy}, 256'd0);
    check("both_widx_later", {250'd0, w_idx}, 256'd0);

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
